// File: rtl/harvard_pkg.sv
// Shared definitions for the Harvard MIPS fetch side: reset vector, NOP encoding, loader states.
package harvard_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_WORD     = 32'h0;

  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} loader_state_t;

  // Drop a byte into lane pos of a word; lane 0 is the most significant byte.
  function automatic logic [31:0] place_byte(logic [31:0] word, logic [1:0] pos, logic [7:0] b);
    logic [31:0] r;
    r = word;
    unique case (pos)
      2'd0: r[31:24] = b;
      2'd1: r[23:16] = b;
      2'd2: r[15:8]  = b;
      2'd3: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_rom_loader_if.sv
// Byte-load handshake plus CPU fetch port of the loadable instruction memory.
interface instr_rom_loader_if #(
  parameter int unsigned DEPTH_WORDS = 256
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic           load_start;
  logic           load_valid;
  logic [7:0]     load_byte;
  logic           load_last;
  logic           load_ready;
  logic           load_done;
  logic           load_overflow;
  logic [IDX_W:0] loaded_words;
  logic [31:0]    instr_address;
  logic [31:0]    instr_readdata;
  logic           misaligned;

  modport master (
    output load_start, load_valid, load_byte, load_last, instr_address,
    input  load_ready, load_done, load_overflow, loaded_words, instr_readdata, misaligned
  );

  modport slave (
    input  load_start, load_valid, load_byte, load_last, instr_address,
    output load_ready, load_done, load_overflow, loaded_words, instr_readdata, misaligned
  );

endinterface

// File: rtl/instr_ram.sv
// Word-wide storage for the instruction image: one synchronous write port, asynchronous read.
module instr_ram #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_rom_loader.sv
// Loadable instruction memory: assembles a big-endian byte stream into words, then serves
// zero-latency fetches in the reset-vector region, returning NOPs outside the loaded image.
module instr_rom_loader
  import harvard_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  instr_rom_loader_if.slave  bus
);

  localparam int unsigned    IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(DEPTH_WORDS);
  localparam logic [IDX_W:0] ONE        = {{IDX_W{1'b0}}, 1'b1};

  loader_state_t  state_q;
  logic [IDX_W:0] count_q;
  logic [1:0]     byte_q;
  logic [31:0]    asm_q;
  logic           overflow_q;
  logic           done_q;

  logic           full;
  logic           accept;
  logic           commit;
  logic [31:0]    word_d;

  logic [29:0]    fetch_idx;
  logic           fetch_misaligned;
  logic           hit;
  logic [31:0]    ram_rdata;

  always_comb begin
    full   = (count_q == FULL_COUNT);
    accept = clk_enable & bus.load_valid & (state_q == LD_LOAD) & ~bus.load_start;
    word_d = place_byte(asm_q, byte_q, bus.load_byte);
    // A final byte mid-word commits the word with its untouched low lanes still zero.
    commit = accept & ~full & ((byte_q == 2'd3) | bus.load_last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LD_IDLE;
      count_q    <= '0;
      byte_q     <= '0;
      asm_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (clk_enable) begin
      if (bus.load_start) begin
        state_q    <= LD_LOAD;
        count_q    <= '0;
        byte_q     <= '0;
        asm_q      <= '0;
        overflow_q <= 1'b0;
        done_q     <= 1'b0;
      end else if (state_q == LD_LOAD && bus.load_valid) begin
        if (full) begin
          overflow_q <= 1'b1;
        end else if (commit) begin
          asm_q   <= '0;
          byte_q  <= '0;
          count_q <= count_q + ONE;
        end else begin
          asm_q  <= word_d;
          byte_q <= byte_q + 2'd1;
        end
        if (bus.load_last) begin
          state_q <= LD_DONE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  instr_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (count_q[IDX_W-1:0]),
    .wdata (word_d),
    .raddr (fetch_idx[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  // Addresses below BASE_ADDR wrap to a huge index and so fall outside the image.
  always_comb begin
    fetch_idx        = 30'((bus.instr_address - BASE_ADDR) >> 2);
    fetch_misaligned = (bus.instr_address[1:0] != 2'b00);
    hit              = done_q & ~fetch_misaligned & ({2'b00, fetch_idx} < 32'(count_q));
  end

  assign bus.instr_readdata = hit ? ram_rdata : NOP_WORD;
  assign bus.misaligned     = fetch_misaligned;
  assign bus.load_ready     = (state_q == LD_LOAD);
  assign bus.load_done      = done_q;
  assign bus.load_overflow  = overflow_q;
  assign bus.loaded_words   = count_q;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Bench for instr_rom_loader: a byte-queue model checked every cycle against two instances
// (256-word and 4-word), plus directed literal expectations.
module tb_instr_rom_loader;
  import harvard_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic clk_enable = 1'b1;

  always #5 clk = ~clk;

  instr_rom_loader_if #(.DEPTH_WORDS(256)) bus_a ();
  instr_rom_loader_if #(.DEPTH_WORDS(4))   bus_b ();

  instr_rom_loader #(.DEPTH_WORDS(256), .BASE_ADDR(BASE)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus_a)
  );

  instr_rom_loader #(.DEPTH_WORDS(4), .BASE_ADDR(BASE)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: accepted bytes kept as a plain list ----------------
  logic [7:0] m_img [2][1024];
  int         m_n   [2];
  logic       m_act [2];
  logic       m_done[2];
  logic       m_ovf [2];

  logic       st_w [2];
  logic       v_w  [2];
  logic       l_w  [2];
  logic [7:0] b_w  [2];
  int         dep_w[2];

  assign st_w[0] = bus_a.load_start;  assign st_w[1] = bus_b.load_start;
  assign v_w[0]  = bus_a.load_valid;  assign v_w[1]  = bus_b.load_valid;
  assign l_w[0]  = bus_a.load_last;   assign l_w[1]  = bus_b.load_last;
  assign b_w[0]  = bus_a.load_byte;   assign b_w[1]  = bus_b.load_byte;
  assign dep_w[0] = 256;              assign dep_w[1] = 4;

  initial begin
    for (int w = 0; w < 2; w++) begin
      m_n[w] = 0; m_act[w] = 1'b0; m_done[w] = 1'b0; m_ovf[w] = 1'b0;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < 2; w++) begin
        m_n[w] <= 0; m_act[w] <= 1'b0; m_done[w] <= 1'b0; m_ovf[w] <= 1'b0;
      end
    end else if (clk_enable) begin
      for (int w = 0; w < 2; w++) begin
        if (st_w[w]) begin
          m_act[w] <= 1'b1; m_done[w] <= 1'b0; m_ovf[w] <= 1'b0; m_n[w] <= 0;
        end else if (m_act[w] && v_w[w]) begin
          if (m_n[w] < 4 * dep_w[w]) begin
            m_img[w][m_n[w]] <= b_w[w];
            m_n[w]           <= m_n[w] + 1;
          end else begin
            m_ovf[w] <= 1'b1;
          end
          if (l_w[w]) begin
            m_act[w] <= 1'b0; m_done[w] <= 1'b1;
          end
        end
      end
    end
  end

  // While loading only whole words count; once finished a trailing partial word counts too.
  function automatic int exp_words(input int w);
    return m_act[w] ? m_n[w] / 4 : (m_n[w] + 3) / 4;
  endfunction

  function automatic logic [31:0] exp_read(input int w, input logic [31:0] addr);
    logic [31:0] idx;
    logic [31:0] word;
    int          k;
    if (!m_done[w] || addr[1:0] != 2'b00) return 32'h0;
    idx = (addr - BASE) >> 2;
    if (idx >= 32'(exp_words(w))) return 32'h0;
    word = 32'h0;
    for (int j = 0; j < 4; j++) begin
      k    = int'(idx) * 4 + j;
      word = {word[23:0], (k < m_n[w]) ? m_img[w][k] : 8'h00};
    end
    return word;
  endfunction

  always @(negedge clk) begin
    chk("a_ready",    32'(bus_a.load_ready),     32'(m_act[0]));
    chk("a_done",     32'(bus_a.load_done),      32'(m_done[0]));
    chk("a_overflow", 32'(bus_a.load_overflow),  32'(m_ovf[0]));
    chk("a_words",    32'(bus_a.loaded_words),   32'(exp_words(0)));
    chk("a_rdata",    bus_a.instr_readdata,      exp_read(0, bus_a.instr_address));
    chk("a_misalign", 32'(bus_a.misaligned),     32'(bus_a.instr_address[1:0] != 2'b00));
    chk("b_ready",    32'(bus_b.load_ready),     32'(m_act[1]));
    chk("b_done",     32'(bus_b.load_done),      32'(m_done[1]));
    chk("b_overflow", 32'(bus_b.load_overflow),  32'(m_ovf[1]));
    chk("b_words",    32'(bus_b.loaded_words),   32'(exp_words(1)));
    chk("b_rdata",    bus_b.instr_readdata,      exp_read(1, bus_b.instr_address));
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_load(input int w);
    if (w == 0) bus_a.load_start = 1'b1; else bus_b.load_start = 1'b1;
    @(posedge clk); #2;
    bus_a.load_start = 1'b0; bus_b.load_start = 1'b0;
  endtask

  task automatic send_byte(input int w, input logic [7:0] b, input logic last);
    if (w == 0) begin
      bus_a.load_valid = 1'b1; bus_a.load_byte = b; bus_a.load_last = last;
    end else begin
      bus_b.load_valid = 1'b1; bus_b.load_byte = b; bus_b.load_last = last;
    end
    @(posedge clk); #2;
    bus_a.load_valid = 1'b0; bus_a.load_last = 1'b0;
    bus_b.load_valid = 1'b0; bus_b.load_last = 1'b0;
  endtask

  task automatic read_chk(input int w, input logic [31:0] addr, input logic [31:0] exp,
                          input string name);
    if (w == 0) bus_a.instr_address = addr; else bus_b.instr_address = addr;
    #1;
    chk(name, (w == 0) ? bus_a.instr_readdata : bus_b.instr_readdata, exp);
  endtask

  task automatic wait_done(input int w, input string name);
    int n = 0;
    while (((w == 0) ? bus_a.load_done : bus_b.load_done) !== 1'b1 && n < 8) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, 32'((w == 0) ? bus_a.load_done : bus_b.load_done), 32'h1);
  endtask

  logic [7:0] t1_bytes [8] = '{8'h24, 8'h84, 8'h00, 8'h0B, 8'h28, 8'h82, 8'hFF, 8'hB3};
  logic [7:0] t3_bytes [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus_a.load_start = 1'b0; bus_a.load_valid = 1'b0; bus_a.load_byte = 8'h00;
    bus_a.load_last  = 1'b0; bus_a.instr_address = BASE;
    bus_b.load_start = 1'b0; bus_b.load_valid = 1'b0; bus_b.load_byte = 8'h00;
    bus_b.load_last  = 1'b0; bus_b.instr_address = BASE;

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    chk("reset_words", 32'(bus_a.loaded_words), 32'h0);
    chk("reset_done",  32'(bus_a.load_done),    32'h0);
    chk("reset_ready", 32'(bus_a.load_ready),   32'h0);

    // T1: two-word image
    start_load(0);
    chk("t1_ready", 32'(bus_a.load_ready), 32'h1);
    for (int i = 0; i < 8; i++) send_byte(0, t1_bytes[i], i == 7);
    wait_done(0, "t1_done_wait");
    chk("t1_words", 32'(bus_a.loaded_words), 32'd2);
    read_chk(0, 32'hBFC00000, 32'h2484000B, "t1_word0");
    read_chk(0, 32'hBFC00004, 32'h2882FFB3, "t1_word1");
    read_chk(0, 32'hBFC00008, 32'h00000000, "t1_past_end");

    // T3: last byte mid-word pads low lanes with zero
    start_load(0);
    for (int i = 0; i < 5; i++) send_byte(0, t3_bytes[i], i == 4);
    wait_done(0, "t3_done_wait");
    chk("t3_words", 32'(bus_a.loaded_words), 32'd2);
    read_chk(0, 32'hBFC00000, 32'hAABBCCDD, "t3_word0");
    read_chk(0, 32'hBFC00004, 32'hEE000000, "t3_word1");

    // T6: clk_enable low freezes everything, including a pending last byte
    start_load(0);
    send_byte(0, 8'hAA, 1'b0); send_byte(0, 8'hBB, 1'b0);
    send_byte(0, 8'hCC, 1'b0); send_byte(0, 8'hDD, 1'b0);
    chk("t6_words_pre", 32'(bus_a.loaded_words), 32'd1);
    clk_enable = 1'b0;
    bus_a.load_valid = 1'b1; bus_a.load_byte = 8'h55; bus_a.load_last = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    bus_a.load_valid = 1'b0; bus_a.load_last = 1'b0;
    chk("t6_words_hold", 32'(bus_a.loaded_words), 32'd1);
    chk("t6_done_hold",  32'(bus_a.load_done),    32'h0);
    chk("t6_ready_hold", 32'(bus_a.load_ready),   32'h1);
    clk_enable = 1'b1;
    send_byte(0, 8'h11, 1'b0); send_byte(0, 8'h22, 1'b0);
    send_byte(0, 8'h33, 1'b0); send_byte(0, 8'h44, 1'b1);
    chk("t6_words", 32'(bus_a.loaded_words), 32'd2);
    read_chk(0, 32'hBFC00004, 32'h11223344, "t6_word1");
    read_chk(0, 32'hBFC00002, 32'h00000000, "t6_misaligned_rd");
    chk("t6_misaligned", 32'(bus_a.misaligned), 32'h1);
    read_chk(0, 32'h00000000, 32'h00000000, "t6_addr_zero");
    read_chk(0, 32'hBFBFFFFC, 32'h00000000, "t6_below_base");

    // T5: async reset mid-word after two committed words
    start_load(0);
    for (int i = 0; i < 10; i++) send_byte(0, 8'(i + 1), 1'b0);
    chk("t5_words_pre", 32'(bus_a.loaded_words), 32'd2);
    bus_a.instr_address = BASE;
    reset = 1'b0;
    #1;
    chk("t5_rst_words", 32'(bus_a.loaded_words),  32'h0);
    chk("t5_rst_done",  32'(bus_a.load_done),     32'h0);
    chk("t5_rst_ready", 32'(bus_a.load_ready),    32'h0);
    chk("t5_rst_ovf",   32'(bus_a.load_overflow), 32'h0);
    chk("t5_rst_rdata", bus_a.instr_readdata,     32'h0);
    #1 reset = 1'b1;
    start_load(0);
    send_byte(0, 8'h12, 1'b0); send_byte(0, 8'h34, 1'b0);
    send_byte(0, 8'h56, 1'b0); send_byte(0, 8'h78, 1'b1);
    chk("t5_words", 32'(bus_a.loaded_words), 32'd1);
    read_chk(0, 32'hBFC00000, 32'h12345678, "t5_word0");
    read_chk(0, 32'hBFC00004, 32'h00000000, "t5_stale_hidden");

    // T4: 4-word instance overfilled with 20 bytes
    start_load(1);
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i + 1), 1'b0);
    chk("t4_words_full", 32'(bus_b.loaded_words),  32'd4);
    chk("t4_ovf_pre",    32'(bus_b.load_overflow), 32'h0);
    for (int i = 16; i < 20; i++) send_byte(1, 8'(i + 1), i == 19);
    wait_done(1, "t4_done_wait");
    chk("t4_ovf",   32'(bus_b.load_overflow), 32'h1);
    chk("t4_words", 32'(bus_b.loaded_words),  32'd4);
    read_chk(1, 32'hBFC0000C, 32'h0D0E0F10, "t4_word3");
    read_chk(1, 32'hBFC00010, 32'h00000000, "t4_past_depth");

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
